mcpu_lsu: RTL
=============

MCPU_LSU -- requirements
Module: mcpu_lsu

Interface
REQ-001 SHALL have parameter DATA_W, 32, bus/data width in bits; power of two, 32 or 64.
REQ-002 SHALL have parameter ADDR_W, 32, byte-address width.
REQ-003 SHALL have parameter TIMEOUT, 255, max wait cycles for MIO_ready; 0 disables timeout.
REQ-004 SHALL have ports, in this order:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  access request from control FSM.
- req_ready  out  1  request accepted this cycle.
- req_we  in  1  1=store, 0=load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 full DATA_W.
- req_signed  in  1  sign-extend load result.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, LSB-aligned.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_W  extended load data.
- rsp_err  out  1  timeout or misalign; qualified by rsp_valid.
- busy  out  1  state not IDLE.
- Addr_out  out  ADDR_W  bus address, lane bits cleared.
- Data_out  out  DATA_W  lane-replicated store data.
- mem_w  out  1  bus write strobe.
- be  out  DATA_W/8  byte enables.
- CPU_MIO  out  1  bus transaction active.
- Data_in  in  DATA_W  bus read data.
- MIO_ready  in  1  bus completion.

Function
REQ-005 SHALL implement FSM IDLE -> BUS -> RESP -> IDLE; req_ready = (state==IDLE).
REQ-006 In IDLE, req_valid=1 SHALL register addr/we/size/signed/wdata and enter BUS next cycle.
REQ-007 In BUS, CPU_MIO=1, mem_w=req_we, be/Addr_out/Data_out driven from registered request; all SHALL be stable until exit.
REQ-008 In BUS, MIO_ready=1 SHALL capture Data_in (loads) and enter RESP; minimum latency is accept at cycle N, rsp_valid at N+2.
REQ-009 In RESP, rsp_valid=1 for exactly one cycle, then IDLE; back-to-back accept in the following cycle SHALL be possible.
REQ-010 Lane index = addr[log2(DATA_W/8)-1:0]; be = size-wide mask shifted by lane index (byte 1, half 2, word 4, full all ones); size 11 with DATA_W=32 SHALL equal word.
REQ-011 Data_out SHALL replicate the low size-bytes of req_wdata across all lanes.
REQ-012 rsp_rdata SHALL be the selected lane shifted to LSBs, zero- or sign-extended per req_signed; stores return rsp_rdata=0.
REQ-013 Wait counter SHALL clear on BUS entry, increment each BUS cycle without MIO_ready; at count==TIMEOUT (TIMEOUT!=0) SHALL drop CPU_MIO, enter RESP with rsp_err=1, rsp_rdata=0.
REQ-014 MIO_ready asserted on the same cycle the timeout fires SHALL win (normal completion, rsp_err=0).
REQ-015 Outside BUS: CPU_MIO=0, mem_w=0, be=0; Addr_out/Data_out SHALL hold last values; req_valid outside IDLE SHALL be ignored.
REQ-016 MIO_ready outside BUS SHALL be ignored.

Reset
REQ-017 rst=0 SHALL asynchronously force IDLE and set all outputs to 0 except req_ready=1, including mid-BUS (in-flight access aborted, no rsp_valid).

Configuration
REQ-018 With LSU_ALIGN_CHECK_EN defined, an access whose address is not a multiple of its size SHALL skip BUS, go IDLE->RESP with rsp_err=1, CPU_MIO never asserted.
REQ-019 Without LSU_ALIGN_CHECK_EN, address bits below the access size SHALL be ignored (forced to 0) and no misalign error occurs.

Structure
REQ-020 Package mcpu_pkg SHALL hold size encodings, FSM state enum, and lane-width constants.
REQ-021 Combinational sub-module mcpu_lsu_lane SHALL compute be, Data_out replication and load extraction/extension; FSM and counters stay in mcpu_lsu.

Verification
REQ-022 DATA_W=32, load byte signed addr 0x103, Data_in 0x80_00_00_00, MIO_ready at first BUS cycle -> be=1000, Addr_out 0x100, rsp_rdata 0xFFFFFF80, rsp_valid 2 cycles after accept.
REQ-023 Store half addr 0x202 wdata 0x0000ABCD -> be=1100, Data_out 0xABCDABCD, mem_w=1 until MIO_ready.
REQ-024 TIMEOUT=4, MIO_ready held 0 -> CPU_MIO drops after 4 BUS cycles, rsp_err=1, rsp_rdata=0.
REQ-025 With LSU_ALIGN_CHECK_EN, word load addr 0x101 -> rsp_err=1 one cycle after accept, CPU_MIO stays 0; without macro -> normal access at 0x100.
REQ-026 rst pulled low during BUS stall -> CPU_MIO/mem_w/be 0 immediately, no rsp_valid, next request accepted after release.
REQ-027 DATA_W=64, load full addr 0x8, Data_in 0x0123456789ABCDEF -> be=0xFF, rsp_rdata 0x0123456789ABCDEF.

Source files
------------

// File: rtl/mcpu_pkg.sv
// mcpu_pkg: access size encodings, LSU state enum and lane-width helpers.
package mcpu_pkg;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_FULL = 2'b11} size_e;
    typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

    function automatic int lane_bits(input int data_w);
        return $clog2(data_w / BYTE_W);
    endfunction

    // Clamp log2(bytes) to the bus width so SZ_FULL on a 32-bit bus means word.
    function automatic logic [1:0] eff_size(input logic [1:0] s, input int lw);
        return (int'(s) > lw) ? 2'(lw) : s;
    endfunction
endpackage

// File: rtl/mcpu_lsu_lane.sv
// mcpu_lsu_lane: byte enables, store-data lane replication and load extraction/extension.
module mcpu_lsu_lane import mcpu_pkg::*; #(
    parameter int DATA_W = 32
) (
    input  logic [1:0]                      size,
    input  logic [lane_bits(DATA_W)-1:0]    lane,
    input  logic                            sgn,
    input  logic [DATA_W-1:0]               wdata,
    input  logic [DATA_W-1:0]               rdata_raw,
    output logic [DATA_W/BYTE_W-1:0]        be,
    output logic [DATA_W-1:0]               data_out,
    output logic [DATA_W-1:0]               rdata
);
    localparam int NB = DATA_W / BYTE_W;

    logic [DATA_W-1:0] sh;
    logic fill;
    int nb;

    always_comb begin
        nb = 1 << size;
        sh = rdata_raw >> {lane, 3'b000};
        fill = sgn & (size == 2'd0 ? sh[7] : size == 2'd1 ? sh[15] : size == 2'd2 ? sh[31] : sh[DATA_W-1]);
        data_out = size == 2'd0 ? {NB{wdata[7:0]}} :
                   size == 2'd1 ? {(NB/2){wdata[15:0]}} :
                   size == 2'd2 ? {(NB/4){wdata[31:0]}} : wdata;
        for (int i = 0; i < NB; i++) begin
            be[i] = i >= int'(lane) && i < int'(lane) + nb;
            rdata[i*BYTE_W +: BYTE_W] = i < nb ? sh[i*BYTE_W +: BYTE_W] : {BYTE_W{fill}};
        end
    end
endmodule

// File: rtl/mcpu_lsu.sv
// mcpu_lsu: single-outstanding load/store unit bridging the control FSM to the MIO bus.
// Define LSU_ALIGN_CHECK_EN to reject misaligned accesses with rsp_err instead of truncating the address.
module mcpu_lsu import mcpu_pkg::*; #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [1:0]               req_size,
    input  logic                     req_signed,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [DATA_W-1:0]        req_wdata,
    output logic                     rsp_valid,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     rsp_err,
    output logic                     busy,
    output logic [ADDR_W-1:0]        Addr_out,
    output logic [DATA_W-1:0]        Data_out,
    output logic                     mem_w,
    output logic [DATA_W/8-1:0]      be,
    output logic                     CPU_MIO,
    input  logic [DATA_W-1:0]        Data_in,
    input  logic                     MIO_ready
);
    localparam int NB = DATA_W / BYTE_W;
    localparam int LW = lane_bits(DATA_W);
    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;

    state_e state;
    logic [ADDR_W-1:0] a_q;
    logic [1:0] sz_q, sz_in;
    logic we_q, sg_q;
    logic [DATA_W-1:0] wd_q, ld;
    logic [LW-1:0] lmask;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [NB-1:0] be_l;

    assign sz_in = eff_size(req_size, LW);
    assign lmask = ~({LW{1'b1}} << sz_in);
    assign cnt_nxt = cnt + 1'b1;
    assign req_ready = state == IDLE;
    assign busy = state != IDLE;
    assign Addr_out = {a_q[ADDR_W-1:LW], {LW{1'b0}}};
    assign be = CPU_MIO ? be_l : '0;
`ifdef LSU_ALIGN_CHECK_EN
    logic mis;
    assign mis = |(req_addr[LW-1:0] & lmask);
`endif

    mcpu_lsu_lane #(.DATA_W(DATA_W)) u_lane (
        .size      (sz_q),
        .lane      (a_q[LW-1:0]),
        .sgn       (sg_q),
        .wdata     (wd_q),
        .rdata_raw (Data_in),
        .be        (be_l),
        .data_out  (Data_out),
        .rdata     (ld)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            a_q <= '0;
            sz_q <= '0;
            we_q <= 1'b0;
            sg_q <= 1'b0;
            wd_q <= '0;
            cnt <= '0;
            CPU_MIO <= 1'b0;
            mem_w <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: if (req_valid) begin
`ifdef LSU_ALIGN_CHECK_EN
                    if (mis) begin
                        state <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err <= 1'b1;
                        rsp_rdata <= '0;
                    end else
`endif
                    begin
                        state <= BUS;
                        a_q <= {req_addr[ADDR_W-1:LW], req_addr[LW-1:0] & ~lmask};
                        sz_q <= sz_in;
                        we_q <= req_we;
                        sg_q <= req_signed;
                        wd_q <= req_wdata;
                        cnt <= '0;
                        CPU_MIO <= 1'b1;
                        mem_w <= req_we;
                    end
                end
                BUS: if (MIO_ready) begin
                    state <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_err <= 1'b0;
                    rsp_rdata <= we_q ? '0 : ld;
                    CPU_MIO <= 1'b0;
                    mem_w <= 1'b0;
                end else if (TIMEOUT != 0 && int'(cnt_nxt) == TIMEOUT) begin
                    state <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_err <= 1'b1;
                    rsp_rdata <= '0;
                    CPU_MIO <= 1'b0;
                    mem_w <= 1'b0;
                end else begin
                    cnt <= cnt_nxt;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
